// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Moore main controller for the multicycle MIPS datapath. Sequences
//   FETCH/DECODE and the per-opcode execute, memory and write-back steps for
//   R-type, LW, SW, BEQ, BNE, ADDI, ORI and J, and drives the datapath mux
//   selects and write enables for each step.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset (-> FETCH)
//   Opcode[OPW-1:0]     IR[31:26], stable after FETCH
//   mem_ready           memory access complete (only with MEM_STALL_EN)
//   MemtoReg, RegDst, IorD, ALUSrcA        datapath mux selects
//   IRWrite, MemWrite, PCWrite, RegWrite   write enables
//   Branch, BranchNe    conditional PC write on Zero / !Zero
//   ImmZext             1 = zero-extend immediate
//   ALUSrcB[1:0]        00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   ALUOp[1:0]          00 add, 01 sub, 10 funct, 11 or
//   PCSrc[1:0]          00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op          unknown opcode seen in DECODE
//   instr_done          last cycle of an instruction
//   state_o[3:0]        current state code, for debug
//
// Build option
//   MEM_STALL_EN        when defined, FETCH, MEMRD and MEMWR wait for
//                       mem_ready; otherwise mem_ready is ignored.
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int             OPW      = 6,
    parameter logic [OPW-1:0] OP_RTYPE = 6'h00,
    parameter logic [OPW-1:0] OP_J     = 6'h02,
    parameter logic [OPW-1:0] OP_BEQ   = 6'h04,
    parameter logic [OPW-1:0] OP_BNE   = 6'h05,
    parameter logic [OPW-1:0] OP_ADDI  = 6'h08,
    parameter logic [OPW-1:0] OP_ORI   = 6'h0D,
    parameter logic [OPW-1:0] OP_LW    = 6'h23,
    parameter logic [OPW-1:0] OP_SW    = 6'h2B
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] Opcode,
    input  logic           mem_ready,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           IorD,
    output logic           ALUSrcA,
    output logic           IRWrite,
    output logic           MemWrite,
    output logic           PCWrite,
    output logic           RegWrite,
    output logic           Branch,
    output logic           BranchNe,
    output logic           ImmZext,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSrc,
    output logic           illegal_op,
    output logic           instr_done,
    output logic [3:0]     state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_ORIEX  = 4'd12,
        S_BNEEX  = 4'd13
    } state_t;

    state_t state, state_next;

`ifdef MEM_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif

    // High while a memory-facing state must wait for the memory.
    logic hold;
    assign hold = STALL_EN & ~mem_ready;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    // NOTE: every output and state_next gets a default before the case, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = S_FETCH;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        ImmZext    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (state)
            S_FETCH: begin
                IRWrite    = ~hold;
                PCWrite    = ~hold;
                ALUSrcB    = 2'b01;
                state_next = hold ? S_FETCH : S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_BNE:       state_next = S_BNEEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_ORI:       state_next = S_ORIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                // Only LW/SW reach here; anything but SW is treated as a load.
                state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                state_next = hold ? S_MEMRD : S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                // The write stays asserted for the whole stall.
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = ~hold;
                state_next = hold ? S_MEMWR : S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_BNEEX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                BranchNe   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = S_IMMWB;
            end
            S_ORIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b11;
                ImmZext    = 1'b1;
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: state_next = S_FETCH;  // unused codes 14, 15
        endcase
    end

    assign state_o = state;

endmodule
